// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard and sequencing controller for a 5-stage
// (F/D/E/M/W) pipeline. It resolves E-stage operand forwarding, detects
// load-use hazards, freezes the pipeline while a variable-latency data
// memory completes an access (with a timeout guard), and counts stall cycles.
module hazard_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemBusy,
  output logic             MemTimeout,
  output logic [WIDTH-1:0] StallCycles
);

  // Wait-cycle counter is 8 bits wide, so the timeout limit is compared
  // in that width (legal limit range is 1..255).
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  // ResultSrcE encoding that marks a load in E.
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Forwarding select encodings.
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       timeout_hit;
  logic       mem_stall;
  logic       load_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Operand source for one E-stage operand. The M-stage result is younger
  // than the W-stage result, so it wins when both write the same register.
  // Register x0 is hardwired to zero and never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Forwarding muxes and load-use detection are purely combinational.
  always_comb begin
    fwd_a      = fwd_select(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    fwd_b      = fwd_select(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    load_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Memory-wait FSM next state: the stall is asserted on the first missing
  // cycle in IDLE, held in WAIT, and dropped the very cycle MemReadyM rises
  // or the wait limit is reached (the access is then abandoned).
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    timeout_hit = 1'b0;
    mem_stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall  = 1'b1;
          state_next = ST_WAIT;
          cnt_next   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (MemReadyM) begin
          state_next = ST_IDLE;
        end else if (cnt == TIMEOUT_CNT) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end else begin
          mem_stall = 1'b1;
          cnt_next  = cnt + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag. Reset during WAIT
  // abandons the access without flagging a timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      MemTimeout <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (timeout_hit) begin
        MemTimeout <= 1'b1;
      end
    end
  end

  // Performance counter: one increment per cycle in which either stall
  // source is active (counted once even when both are); wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCycles <= '0;
    end else if (mem_stall || load_stall) begin
      StallCycles <= StallCycles + WIDTH'(1);
    end
  end

  // Pipeline control priority: reset, memory stall, load-use, branch.
  // Pipeline registers have no reset of their own, so reset flushes them.
  // A memory stall freezes everything and suppresses branch/load-use
  // actions; those re-evaluate once the pipeline moves again.
  always_comb begin
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemBusy   = (state == ST_WAIT);
    if (!rst_n) begin
      ForwardAE = FWD_REGFILE;
      ForwardBE = FWD_REGFILE;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (load_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      FlushD = PCSrcE;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with a short wait limit (4).
// Inputs change on the falling edge; outputs are compared 2 ns later, before
// the next rising edge. Expected values go through a scoreboard queue.
module tb_hazard_ctrl;

  localparam int WIDTH       = 32;
  localparam int MEM_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemBusy, MemTimeout;
  logic [WIDTH-1:0] StallCycles;

  // Observed control word: {FA, FB, StallF/D/E/M, FlushD/E/W, MemBusy, MemTimeout}
  logic [12:0] act_ctl;
  assign act_ctl = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushW, MemBusy, MemTimeout};

  typedef struct {
    string            tag;
    logic [12:0]      ctl;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl #(.WIDTH(WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemBusy(MemBusy), .MemTimeout(MemTimeout),
    .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Push the expectation for the stimulus just driven, let it settle,
  // then pop and compare against the DUT.
  task automatic expect_out(input string tag, input logic [12:0] ctl,
                            input logic [WIDTH-1:0] cnt);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.cnt = cnt;
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    checks++;
    assert (act_ctl === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl: observed %b expected %b", e.tag, act_ctl, e.ctl);
    end
    checks++;
    assert (StallCycles === e.cnt) else begin
      errors++;
      $error("FAIL %s StallCycles: observed %0d expected %0d", e.tag, StallCycles, e.cnt);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Forwarding conditions present during reset must be ignored.
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; PCSrcE = 1'b1;
    @(negedge clk);
    //                         FA FB SFDEM  FDEW B T
    expect_out("reset",      13'b00_00_0000_111_0_0, 0);

    // Forwarding: M wins over W, then W alone, then B operand, then x0.
    @(negedge clk); clear_inputs(); rst_n = 1'b1;
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd0;
    expect_out("fwd_m_wins", 13'b10_00_0000_000_0_0, 0);
    @(negedge clk); RdM = 5'd0;
    expect_out("fwd_w",      13'b01_00_0000_000_0_0, 0);
    @(negedge clk); RdM = 5'd3; Rs1E = 5'd3; Rs2E = 5'd5;
    expect_out("fwd_ab",     13'b10_01_0000_000_0_0, 0);
    @(negedge clk); RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    expect_out("fwd_x0",     13'b00_00_0000_000_0_0, 0);

    // Load-use hazard, then with a taken branch, then with RdE = x0.
    @(negedge clk); clear_inputs(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    expect_out("load_use",   13'b00_00_1100_010_0_0, 0);
    @(negedge clk); PCSrcE = 1'b1;
    expect_out("load_br",    13'b00_00_1100_110_0_0, 1);
    @(negedge clk); PCSrcE = 1'b0; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    expect_out("load_x0",    13'b00_00_0000_000_0_0, 2);
    @(negedge clk); clear_inputs(); PCSrcE = 1'b1;
    expect_out("branch",     13'b00_00_0000_110_0_0, 2);

    // Zero-wait access: no stall, FSM stays IDLE.
    @(negedge clk); clear_inputs(); MemReqM = 1'b1; MemReadyM = 1'b1;
    expect_out("zw_access",  13'b00_00_0000_000_0_0, 2);
    @(negedge clk); clear_inputs();
    expect_out("zw_idle",    13'b00_00_0000_000_0_0, 2);

    // Three-cycle wait; a taken branch during WAIT is suppressed until ready.
    @(negedge clk); MemReqM = 1'b1; MemReadyM = 1'b0;
    expect_out("wait_c0",    13'b00_00_1111_001_0_0, 2);
    @(negedge clk); PCSrcE = 1'b1;
    expect_out("wait_c1_br", 13'b00_00_1111_001_1_0, 3);
    @(negedge clk);
    expect_out("wait_c2_br", 13'b00_00_1111_001_1_0, 4);
    @(negedge clk); MemReadyM = 1'b1;
    expect_out("wait_ready", 13'b00_00_0000_110_1_0, 5);
    @(negedge clk); clear_inputs();
    expect_out("wait_done",  13'b00_00_0000_000_0_0, 5);

    // Timeout: ready held low; stall for 4 cycles, flag after 5th edge.
    @(negedge clk); MemReqM = 1'b1; MemReadyM = 1'b0;
    expect_out("to_c0",      13'b00_00_1111_001_0_0, 5);
    @(negedge clk);
    expect_out("to_c1",      13'b00_00_1111_001_1_0, 6);
    @(negedge clk);
    expect_out("to_c2",      13'b00_00_1111_001_1_0, 7);
    @(negedge clk);
    expect_out("to_c3",      13'b00_00_1111_001_1_0, 8);
    @(negedge clk);
    expect_out("to_limit",   13'b00_00_0000_000_1_0, 9);
    @(negedge clk); clear_inputs();
    expect_out("to_sticky",  13'b00_00_0000_000_0_1, 9);
    @(negedge clk);
    expect_out("to_sticky2", 13'b00_00_0000_000_0_1, 9);

    // Reset in the middle of WAIT with a branch pending.
    @(negedge clk); MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    expect_out("rw_c0",      13'b00_00_1111_001_0_1, 9);
    @(negedge clk);
    expect_out("rw_c1",      13'b00_00_1111_001_1_1, 10);
    @(negedge clk); rst_n = 1'b0;
    expect_out("rw_rst_in",  13'b00_00_0000_111_1_1, 11);
    @(negedge clk);
    expect_out("rw_rst_clr", 13'b00_00_0000_111_0_0, 0);
    @(negedge clk); clear_inputs(); rst_n = 1'b1;
    expect_out("rw_release", 13'b00_00_0000_000_0_0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
